// File: rtl/avalon_pulse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : avalon_pulse_pkg
// Description : Shared definitions for the Avalon pulse controller: register
//               word addresses, pulse channel state encoding and the default
//               ID/version constant.
// Revision    : 1.0 - initial release
// ============================================================================
package avalon_pulse_pkg;

    // Register word addresses
    localparam logic [2:0] ADDR_CMD       = 3'd0;
    localparam logic [2:0] ADDR_MODE      = 3'd1;
    localparam logic [2:0] ADDR_STATUS    = 3'd2;
    localparam logic [2:0] ADDR_IRQ_MASK  = 3'd3;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd4;
    localparam logic [2:0] ADDR_BUSY      = 3'd5;
    localparam logic [2:0] ADDR_ID        = 3'd6;

    // Pulse channel state encoding
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } chan_state_t;

    // Value returned by the ID register unless overridden
    localparam logic [31:0] DEFAULT_VERSION = 32'h0002_0000;

endpackage : avalon_pulse_pkg
`default_nettype wire

// File: rtl/pulse_chan.sv
`default_nettype none
// ============================================================================
// Module      : pulse_chan
// Description : One strobe channel. A trigger seen while idle and enabled
//               starts a pulse of exactly len cycles; triggers during a pulse
//               are ignored and dropping the enable aborts the pulse.
// Ports       : clk, rst  - clock, synchronous active-high reset
//               trig      - start request (one-cycle strobe)
//               en        - channel enable
//               len       - effective pulse length in cycles (must be >= 1)
//               raw       - pulse level before output inversion
//               busy      - pulse in progress
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_chan
    import avalon_pulse_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic             en,
    input  logic [LEN_W-1:0] len,
    output logic             raw,
    output logic             busy
);

    chan_state_t      r_state;
    logic [LEN_W-1:0] r_cnt;
    logic             r_raw;

    // r_cnt holds the number of pulse cycles remaining including the current
    // one, so the pulse ends on the edge where it reads 1. The "<= 1" guard
    // keeps a zero length from wrapping into a very long pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_raw   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (trig && en) begin
                        r_state <= ST_ACTIVE;
                        r_cnt   <= len;
                        r_raw   <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (!en || (r_cnt <= LEN_W'(1))) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_raw   <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt - LEN_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_raw   <= 1'b0;
                end
            endcase
        end
    end

    assign raw  = r_raw;
    assign busy = r_raw;

endmodule : pulse_chan
`default_nettype wire

// File: rtl/avalon_pulse_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : avalon_pulse_ctrl
// Description : Avalon-MM slave controlling NUM_CH strobe channels. Each
//               channel has a self-clearing trigger, enable/invert bits, a
//               sticky W1C event flag and a maskable level interrupt.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               avs_s0_*             - Avalon-MM slave, read latency 1
//               evt_in[NUM_CH]       - event levels (synchronous to clk)
//               pulse_out[NUM_CH]    - channel pulses after inversion
//               irq                  - registered level interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_pulse_ctrl
    import avalon_pulse_pkg::*;
#(
    parameter int          NUM_CH  = 3,
    parameter int          DATA_W  = 32,
    parameter int          ADDR_W  = 4,
    parameter int          LEN_W   = 8,
    parameter logic [31:0] VERSION = DEFAULT_VERSION
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] avs_s0_address,
    input  logic [DATA_W-1:0] avs_s0_writedata,
    input  logic              avs_s0_write,
    input  logic              avs_s0_read,
    output logic [DATA_W-1:0] avs_s0_readdata,
    output logic              avs_s0_readdatavalid,
    input  logic [NUM_CH-1:0] evt_in,
    output logic [NUM_CH-1:0] pulse_out,
    output logic              irq
);

    // Registers
    logic [2*NUM_CH-1:0] r_mode;
    logic [NUM_CH-1:0]   r_status;
    logic [NUM_CH-1:0]   r_mask;
    logic [LEN_W-1:0]    r_len;
    logic [NUM_CH-1:0]   r_evt_prev;
    logic                r_irq;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rdv;

    // Decode and datapath
    logic                w_wr_cmd;
    logic                w_wr_mode;
    logic                w_wr_status;
    logic                w_wr_mask;
    logic                w_wr_len;
    logic [NUM_CH-1:0]   w_trig;
    logic [NUM_CH-1:0]   w_en;
    logic [NUM_CH-1:0]   w_inv;
    logic [LEN_W-1:0]    w_len_eff;
    logic [NUM_CH-1:0]   w_rise;
    logic [NUM_CH-1:0]   w_clr;
    logic [NUM_CH-1:0]   w_raw;
    logic [NUM_CH-1:0]   w_busy;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_unused_wdata;

    assign w_wr_cmd    = avs_s0_write && (avs_s0_address == ADDR_W'(ADDR_CMD));
    assign w_wr_mode   = avs_s0_write && (avs_s0_address == ADDR_W'(ADDR_MODE));
    assign w_wr_status = avs_s0_write && (avs_s0_address == ADDR_W'(ADDR_STATUS));
    assign w_wr_mask   = avs_s0_write && (avs_s0_address == ADDR_W'(ADDR_IRQ_MASK));
    assign w_wr_len    = avs_s0_write && (avs_s0_address == ADDR_W'(ADDR_PULSE_LEN));

    assign w_trig    = w_wr_cmd    ? avs_s0_writedata[NUM_CH-1:0] : '0;
    assign w_clr     = w_wr_status ? avs_s0_writedata[NUM_CH-1:0] : '0;
    assign w_en      = r_mode[NUM_CH-1:0];
    assign w_inv     = r_mode[2*NUM_CH-1:NUM_CH];
    assign w_len_eff = (r_len == '0) ? LEN_W'(1) : r_len;
    assign w_rise    = evt_in & ~r_evt_prev;

    // Upper write-data bits have no register behind them
    assign w_unused_wdata = ^avs_s0_writedata;

    // Register file, event capture, interrupt and read response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode     <= '0;
            r_status   <= '0;
            r_mask     <= '0;
            r_len      <= LEN_W'(1);
            r_evt_prev <= '0;
            r_irq      <= 1'b0;
            r_rdata    <= '0;
            r_rdv      <= 1'b0;
        end else begin
            if (w_wr_mode) r_mode <= avs_s0_writedata[2*NUM_CH-1:0];
            if (w_wr_mask) r_mask <= avs_s0_writedata[NUM_CH-1:0];
            if (w_wr_len)  r_len  <= avs_s0_writedata[LEN_W-1:0];
            // Set is OR-ed in after the clear so a coincident event wins
            r_status   <= (r_status & ~w_clr) | w_rise;
            r_evt_prev <= evt_in;
            r_irq      <= |(r_status & r_mask);
            r_rdv      <= avs_s0_read;
            // Mux reads the pre-edge registers, so a same-cycle write to the
            // addressed register returns the old value
            if (avs_s0_read) r_rdata <= w_rdata;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (avs_s0_address)
            ADDR_W'(ADDR_MODE):      w_rdata = DATA_W'(r_mode);
            ADDR_W'(ADDR_STATUS):    w_rdata = DATA_W'(r_status);
            ADDR_W'(ADDR_IRQ_MASK):  w_rdata = DATA_W'(r_mask);
            ADDR_W'(ADDR_PULSE_LEN): w_rdata = DATA_W'(r_len);
            ADDR_W'(ADDR_BUSY):      w_rdata = DATA_W'(w_busy);
            ADDR_W'(ADDR_ID):        w_rdata = DATA_W'(VERSION);
            default:                 w_rdata = '0;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            pulse_chan #(
                .LEN_W (LEN_W)
            ) u_chan (
                .clk  (clk),
                .rst  (rst),
                .trig (w_trig[gi]),
                .en   (w_en[gi]),
                .len  (w_len_eff),
                .raw  (w_raw[gi]),
                .busy (w_busy[gi])
            );
        end
    endgenerate

    assign pulse_out            = w_raw ^ w_inv;
    assign irq                  = r_irq;
    assign avs_s0_readdata      = r_rdata;
    assign avs_s0_readdatavalid = r_rdv;

endmodule : avalon_pulse_ctrl
`default_nettype wire

// File: tb/tb_avalon_pulse_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_avalon_pulse_ctrl
// Description : Self-checking bench for avalon_pulse_ctrl. Read responses are
//               checked by a scoreboard monitor; pulse/irq levels are checked
//               directly by the stimulus on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_pulse_ctrl;

    localparam int NUM_CH = 3;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int LEN_W  = 8;

    localparam logic [3:0] A_CMD    = 4'd0;
    localparam logic [3:0] A_MODE   = 4'd1;
    localparam logic [3:0] A_STATUS = 4'd2;
    localparam logic [3:0] A_MASK   = 4'd3;
    localparam logic [3:0] A_LEN    = 4'd4;
    localparam logic [3:0] A_BUSY   = 4'd5;
    localparam logic [3:0] A_ID     = 4'd6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] avs_s0_address   = '0;
    logic [DATA_W-1:0] avs_s0_writedata = '0;
    logic              avs_s0_write     = 1'b0;
    logic              avs_s0_read      = 1'b0;
    logic [DATA_W-1:0] avs_s0_readdata;
    logic              avs_s0_readdatavalid;
    logic [NUM_CH-1:0] evt_in = '0;
    logic [NUM_CH-1:0] pulse_out;
    logic              irq;

    avalon_pulse_ctrl #(
        .NUM_CH  (NUM_CH),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .LEN_W   (LEN_W),
        .VERSION (32'h0002_0000)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .avs_s0_address       (avs_s0_address),
        .avs_s0_writedata     (avs_s0_writedata),
        .avs_s0_write         (avs_s0_write),
        .avs_s0_read          (avs_s0_read),
        .avs_s0_readdata      (avs_s0_readdata),
        .avs_s0_readdatavalid (avs_s0_readdatavalid),
        .evt_in               (evt_in),
        .pulse_out            (pulse_out),
        .irq                  (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] v;
        string       n;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic exp_rdv  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Expected readdatavalid: a read accepted on an edge answers after it
    always @(posedge clk) exp_rdv <= rst ? 1'b0 : avs_s0_read;

    // Monitor: pops an expected read value whenever the DUT presents data
    always @(negedge clk) begin
        chk("readdatavalid", 32'(avs_s0_readdatavalid), 32'(exp_rdv));
        if (avs_s0_readdatavalid) begin
            if (sb.size() == 0) begin
                chk("unexpected readdata", 32'(1), 32'(0));
            end else begin
                mon_e = sb.pop_front();
                chk(mon_e.n, avs_s0_readdata, mon_e.v);
            end
        end
    end

    // All tasks start and end on a falling edge
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        avs_s0_address   = a;
        avs_s0_writedata = d;
        avs_s0_write     = 1'b1;
        @(negedge clk);
        avs_s0_write     = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e, input string nm);
        avs_s0_address = a;
        avs_s0_read    = 1'b1;
        sb.push_back('{v: e, n: nm});
        @(negedge clk);
        avs_s0_read    = 1'b0;
    endtask

    initial begin
        // 1: reset state and basic reads
        repeat (3) @(negedge clk);
        chk("reset pulse_out", 32'(pulse_out), 32'd0);
        chk("reset irq", 32'(irq), 32'd0);
        chk("reset readdata", avs_s0_readdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        rd(A_ID,   32'h0002_0000, "read ID");
        rd(A_MODE, 32'd0, "reset MODE");
        rd(A_LEN,  32'd1, "reset PULSE_LEN");
        rd(A_STATUS, 32'd0, "reset STATUS");
        rd(A_CMD,  32'd0, "CMD reads 0");
        rd(4'd7,   32'd0, "unmapped reads 0");
        wr(4'd9,   32'hFFFF_FFFF);
        rd(A_MASK, 32'd0, "unmapped write ignored");

        // 2: two channels, 4-cycle pulses, BUSY mid-pulse
        wr(A_MODE, 32'h7);
        wr(A_LEN,  32'd4);
        wr(A_CMD,  32'h5);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t2 pulse c%0d", i), 32'(pulse_out), (i < 4) ? 32'd5 : 32'd0);
            if (i == 1) begin
                avs_s0_address = A_BUSY;
                avs_s0_read    = 1'b1;
                sb.push_back('{v: 32'd5, n: "t2 BUSY mid-pulse"});
            end else begin
                avs_s0_read = 1'b0;
            end
            @(negedge clk);
        end
        avs_s0_read = 1'b0;

        // 3: retrigger during pulse ignored, disabled channel ignored
        wr(A_MODE, 32'h1);
        wr(A_LEN,  32'd5);
        wr(A_CMD,  32'h1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3 pulse c%0d", i), 32'(pulse_out), (i < 5) ? 32'd1 : 32'd0);
            if (i == 1) begin
                avs_s0_address   = A_CMD;
                avs_s0_writedata = 32'h1;
                avs_s0_write     = 1'b1;
            end else begin
                avs_s0_write = 1'b0;
            end
            @(negedge clk);
        end
        avs_s0_write = 1'b0;
        wr(A_CMD, 32'h2);
        chk("t3 disabled ch c0", 32'(pulse_out), 32'd0);
        @(negedge clk);
        chk("t3 disabled ch c1", 32'(pulse_out), 32'd0);
        rd(A_BUSY, 32'd0, "t3 BUSY idle");

        // 4: inverted channel idles high, pulses low
        wr(A_MODE, 32'h9);
        chk("t4 invert idle", 32'(pulse_out), 32'd1);
        wr(A_LEN, 32'd2);
        wr(A_CMD, 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4 pulse c%0d", i), 32'(pulse_out), (i < 2) ? 32'd0 : 32'd1);
            @(negedge clk);
        end

        // 5: events, W1C, set-wins, masked irq
        wr(A_MASK, 32'h2);
        evt_in = 3'b010;
        @(negedge clk);
        chk("t5 irq one cycle late", 32'(irq), 32'd0);
        rd(A_STATUS, 32'h2, "t5 STATUS set");
        chk("t5 irq set", 32'(irq), 32'd1);
        evt_in = 3'b000;
        @(negedge clk);
        evt_in = 3'b010;
        wr(A_STATUS, 32'h2);
        rd(A_STATUS, 32'h2, "t5 set wins over clear");
        chk("t5 irq held", 32'(irq), 32'd1);
        evt_in = 3'b000;
        wr(A_STATUS, 32'h2);
        rd(A_STATUS, 32'h0, "t5 STATUS cleared");
        chk("t5 irq cleared", 32'(irq), 32'd0);
        evt_in = 3'b001;
        @(negedge clk);
        rd(A_STATUS, 32'h1, "t5 masked event flag");
        chk("t5 masked irq", 32'(irq), 32'd0);
        evt_in = 3'b000;
        wr(A_STATUS, 32'h1);

        // Simultaneous read and write: read returns pre-write value
        avs_s0_address   = A_MODE;
        avs_s0_writedata = 32'h1;
        avs_s0_write     = 1'b1;
        avs_s0_read      = 1'b1;
        sb.push_back('{v: 32'h9, n: "rw old MODE"});
        @(negedge clk);
        avs_s0_write = 1'b0;
        avs_s0_read  = 1'b0;
        rd(A_MODE, 32'h1, "rw new MODE");
        chk("rw invert off", 32'(pulse_out), 32'd0);

        // Enable cleared during a pulse aborts it
        wr(A_LEN, 32'd10);
        wr(A_CMD, 32'h1);
        chk("abort pulse started", 32'(pulse_out), 32'd1);
        wr(A_MODE, 32'h0);
        @(negedge clk);
        chk("abort pulse ended", 32'(pulse_out), 32'd0);
        rd(A_BUSY, 32'd0, "abort BUSY");

        // 6: reset mid-pulse
        wr(A_MODE, 32'h1);
        wr(A_CMD, 32'h1);
        chk("t6 pulse started", 32'(pulse_out), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6 pulse after rst", 32'(pulse_out), 32'd0);
        chk("t6 readdata after rst", avs_s0_readdata, 32'd0);
        rd(A_BUSY, 32'd0, "t6 BUSY after rst");
        rd(A_LEN,  32'd1, "t6 PULSE_LEN after rst");
        rd(A_MODE, 32'd0, "t6 MODE after rst");

        // Length 0 behaves as 1
        wr(A_MODE, 32'h1);
        wr(A_LEN,  32'd0);
        wr(A_CMD,  32'h1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("len0 pulse c%0d", i), 32'(pulse_out), (i < 1) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        rd(A_LEN, 32'd0, "len0 readback");

        repeat (3) @(negedge clk);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_avalon_pulse_ctrl
`default_nettype wire
